// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART transmitter among NUM_REQ byte sources. A round-robin
// arbiter accepts one byte at a time and appends an optional parity bit as
// the MSB. It then strobes the transmitter load. Further grants are held off
// until the transmitter's busy flag has risen and fallen again, or until busy
// fails to rise within BUSY_TIMEOUT cycles. A free-running baud tick paces
// the transmitter.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   req_valid    per-requester byte available
//   req_data     requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    one-hot accept strobe (combinational, IDLE only)
//   tx_enable    one-cycle load strobe to the transmitter
//   tx_data      {parity, data}, held from load until the next grant
//   tx_busy      transmitter busy flag
//   baud_tick    one-cycle pulse every CLKS_PER_BIT cycles
//   grant_id     index of the last/current granted requester
//   active       high whenever a byte is in flight
//   timeout_err  one-cycle pulse when busy never rose after a load
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_ENABLED = 1,
  parameter int PARITY_ODD     = 0,
  parameter int CLKS_PER_BIT   = 16,
  parameter int BUSY_TIMEOUT   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 tx_enable,
  output logic [DATA_WIDTH+PARITY_ENABLED-1:0] tx_data,
  input  logic                                 tx_busy,
  output logic                                 baud_tick,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 active,
  output logic                                 timeout_err
);

  localparam int TX_W   = DATA_WIDTH + PARITY_ENABLED;
  localparam int GID_W  = $clog2(NUM_REQ);
  localparam int TMO_W  = $clog2(BUSY_TIMEOUT);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [GID_W-1:0]  winner;
  logic [GID_W-1:0]  cand;
  logic              any_valid;
  logic [DATA_WIDTH-1:0] win_data;
  logic [TX_W-1:0]   frame;
  logic [TMO_W-1:0]  busy_cnt;
  logic [BAUD_W-1:0] baud_cnt;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction

  // Round-robin search starting just after the previous grant; the first
  // valid requester found in that order wins.
  always_comb begin
    winner    = grant_id;
    cand      = grant_id;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GID_W'((int'(grant_id) + k) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
    win_data  = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    req_ready = '0;
    // Gated by reset_n so no accept is signalled while reset is applied.
    if (state == IDLE && reset_n && any_valid)
      req_ready[winner] = 1'b1;
  end

  if (PARITY_ENABLED != 0) begin : g_parity
    assign frame = {parity_bit(win_data), win_data};
  end else begin : g_no_parity
    assign frame = win_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      tx_enable   <= 1'b0;
      tx_data     <= '0;
      grant_id    <= GID_W'(NUM_REQ - 1);
      active      <= 1'b0;
      timeout_err <= 1'b0;
      busy_cnt    <= '0;
    end else begin
      tx_enable   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            tx_data   <= frame;
            grant_id  <= winner;
            tx_enable <= 1'b1;
            active    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
            // busy has been low for BUSY_TIMEOUT sampled cycles
            timeout_err <= 1'b1;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Free-running baud counter, independent of the scheduler state.
  always_ff @(posedge clk) begin
    if (!reset_n)
      baud_cnt <= '0;
    else if (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1))
      baud_cnt <= '0;
    else
      baud_cnt <= baud_cnt + 1'b1;
  end

  assign baud_tick = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

endmodule
